// File: rtl/regbank_seq_pkg.sv
// -----------------------------------------------------------------------------
// regbank_pkg
//   Shared definitions for the register-bank command sequencer:
//     - default data / register-select widths
//     - command op codes (OP_LOAD/OP_ADD/OP_SUB/OP_MOVE)
//     - sequencer FSM state encodings (ST_IDLE/ST_READ/ST_EXEC/ST_WRITE)
//   Optional feature macro used by the importing files: REGBANK_SEQ_FLAGS_EN.
// -----------------------------------------------------------------------------
package regbank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MOVE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/regbank_seq_alu.sv
// -----------------------------------------------------------------------------
// regbank_seq_alu
//   Combinational op unit used by the sequencer in its EXEC state.
//   Arithmetic wraps modulo 2^DATA_W.
//   Ports:
//     i_op      op code (LOAD / ADD / SUB / MOVE)
//     i_a, i_b  captured operands (bank read ports 1 and 2)
//     i_imm     immediate for LOAD
//     o_result  DATA_W-bit result
//     o_carry   carry-out of ADD, borrow of SUB, 0 otherwise
//               (present only when REGBANK_SEQ_FLAGS_EN is defined)
// -----------------------------------------------------------------------------
module regbank_seq_alu
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
`ifdef REGBANK_SEQ_FLAGS_EN
    output logic              o_carry,
`endif
    output logic [DATA_W-1:0] o_result
);

`ifdef REGBANK_SEQ_FLAGS_EN
    // One extra bit on top holds the carry (ADD) or the borrow (SUB).
    logic [DATA_W:0] w_ext;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_ext = '0;
        case (op_e'(i_op))
            OP_LOAD: w_ext = {1'b0, i_imm};
            OP_ADD:  w_ext = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_ext = {1'b0, i_a} - {1'b0, i_b};
            OP_MOVE: w_ext = {1'b0, i_a};
            default: w_ext = '0;
        endcase
    end

    assign o_result = w_ext[DATA_W-1:0];
    assign o_carry  = w_ext[DATA_W];
`else
    always_comb begin
        o_result = '0;
        case (op_e'(i_op))
            OP_LOAD: o_result = i_imm;
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_MOVE: o_result = i_a;
            default: o_result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/regbank_seq.sv
// -----------------------------------------------------------------------------
// regbank_seq
//   Command sequencer acting as master of a 4x32 register bank. Accepts one
//   LOAD/ADD/SUB/MOVE command per valid/ready handshake and runs it through
//   IDLE -> READ -> EXEC -> WRITE, one cycle each.
//   Optional feature: REGBANK_SEQ_FLAGS_EN adds flag_z / flag_c outputs.
//   Ports:
//     clk, rst           clock; synchronous active-high reset
//     cmd_valid/ready    command handshake (ready only in IDLE, rst low)
//     cmd_op/sr1/sr2/dr  command op code and register selects
//     cmd_imm            immediate for LOAD
//     sr1, sr2           bank read selects (latched command selects)
//     rData1, rData2     bank read data (combinational in the bank)
//     dr, wrData, write  bank write select / data / one-cycle enable
//     busy               sequencer not in IDLE
//     done               one-cycle pulse coincident with write
//     flag_z, flag_c     zero / carry-borrow of last result (flags build)
// -----------------------------------------------------------------------------
module regbank_seq
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_sr1,
    input  logic [ADDR_W-1:0] cmd_sr2,
    input  logic [ADDR_W-1:0] cmd_dr,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] sr1,
    output logic [ADDR_W-1:0] sr2,
    input  logic [DATA_W-1:0] rData1,
    input  logic [DATA_W-1:0] rData2,
    output logic [ADDR_W-1:0] dr,
    output logic [DATA_W-1:0] wrData,
    output logic              write,
    output logic              busy,
`ifdef REGBANK_SEQ_FLAGS_EN
    output logic              flag_z,
    output logic              flag_c,
`endif
    output logic              done
);

    state_e            r_state;
    op_e               r_op;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ADDR_W-1:0] r_sr1;
    logic [ADDR_W-1:0] r_sr2;
    logic [ADDR_W-1:0] r_dr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] w_result;
`ifdef REGBANK_SEQ_FLAGS_EN
    logic              w_carry;
    logic              r_carry;
    logic              r_flag_z;
    logic              r_flag_c;
`endif

    regbank_seq_alu #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
`ifdef REGBANK_SEQ_FLAGS_EN
        .o_carry  (w_carry),
`endif
        .o_result (w_result)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_LOAD;
            r_imm     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
            r_dr      <= '0;
            r_wr_data <= '0;
`ifdef REGBANK_SEQ_FLAGS_EN
            r_carry   <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
`endif
        end else begin
            case (r_state)
                // cmd_ready is IDLE & ~rst, and rst is low here, so valid
                // alone completes the handshake.
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= op_e'(cmd_op);
                        r_imm   <= cmd_imm;
                        r_sr1   <= cmd_sr1;
                        r_sr2   <= cmd_sr2;
                        r_dr    <= cmd_dr;
                        r_state <= ST_READ;
                    end
                end
                // Operands are captured before any write, so dr may alias
                // sr1/sr2 safely. LOAD still takes this cycle.
                ST_READ: begin
                    r_a     <= rData1;
                    r_b     <= rData2;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_wr_data <= w_result;
`ifdef REGBANK_SEQ_FLAGS_EN
                    r_carry   <= w_carry;
`endif
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
`ifdef REGBANK_SEQ_FLAGS_EN
                    r_flag_z <= (r_wr_data == '0);
                    r_flag_c <= r_carry;
`endif
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gating with rst means a reset landing in the WRITE cycle never
    // reaches the bank and never reports completion.
    assign write     = (r_state == ST_WRITE) & ~rst;
    assign done      = write;
    assign cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign busy      = (r_state != ST_IDLE);
    assign sr1       = r_sr1;
    assign sr2       = r_sr2;
    assign dr        = r_dr;
    assign wrData    = r_wr_data;
`ifdef REGBANK_SEQ_FLAGS_EN
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
`endif

endmodule

// File: tb/tb_regbank_seq.sv
// -----------------------------------------------------------------------------
// tb_regbank_seq
//   Bench for regbank_seq paired with a 4x32 register-bank model. Expected
//   results come from a reference register array updated with plain
//   arithmetic per command. Define REGBANK_SEQ_FLAGS_EN to also check flags.
// -----------------------------------------------------------------------------
module tb_regbank_seq;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] SUB  = 2'b10;
    localparam logic [1:0] MOVE = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_sr1;
    logic [1:0]  cmd_sr2;
    logic [1:0]  cmd_dr;
    logic [31:0] cmd_imm;
    logic [1:0]  sr1;
    logic [1:0]  sr2;
    logic [31:0] rData1;
    logic [31:0] rData2;
    logic [1:0]  dr;
    logic [31:0] wrData;
    logic        write;
    logic        busy;
    logic        done;
`ifdef REGBANK_SEQ_FLAGS_EN
    logic        flag_z;
    logic        flag_c;
`endif

    // Bank model (environment) and reference register file (expectations).
    logic [31:0] bank     [4] = '{default: 32'h0};
    logic [31:0] ref_regs [4] = '{default: 32'h0};
    logic        ref_z = 1'b0;
    logic        ref_c = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    regbank_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sr1   (cmd_sr1),
        .cmd_sr2   (cmd_sr2),
        .cmd_dr    (cmd_dr),
        .cmd_imm   (cmd_imm),
        .sr1       (sr1),
        .sr2       (sr2),
        .rData1    (rData1),
        .rData2    (rData2),
        .dr        (dr),
        .wrData    (wrData),
        .write     (write),
        .busy      (busy),
`ifdef REGBANK_SEQ_FLAGS_EN
        .flag_z    (flag_z),
        .flag_c    (flag_c),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    assign rData1 = bank[sr1];
    assign rData2 = bank[sr2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        if (write) bank[dr] <= wrData;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference semantics of one command, from operand values at acceptance.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        longint sum;
        case (op)
            LOAD:    return {1'b0, imm};
            ADD: begin
                sum = longint'(a) + longint'(b);
                return {sum > 64'h0000_0000_FFFF_FFFF, sum[31:0]};
            end
            SUB: begin
                sum = longint'(a) - longint'(b);
                return {a < b, sum[31:0]};
            end
            default: return {1'b0, a};
        endcase
    endfunction

    // Issue one command and follow it through to completion. With hold set,
    // cmd_valid stays high after the handshake.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [1:0] d, input logic [31:0] imm, input bit hold,
                           output int hs_cyc);
        logic [32:0] exp;
        bit          got;
        cmd_op    = op;
        cmd_sr1   = s1;
        cmd_sr2   = s2;
        cmd_dr    = d;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        hs_cyc    = 0;
        got       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("ready_wait", 32'(got), 32'd1);
        if (!got) begin
            cmd_valid = 1'b0;
            return;
        end
        tick();
        hs_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
        exp = model(op, ref_regs[s1], ref_regs[s2], imm);
        // READ
        check("read_busy",  32'(busy), 32'd1);
        check("read_ready", 32'(cmd_ready), 32'd0);
        check("read_write", 32'(write), 32'd0);
        check("read_sr1",   32'(sr1), 32'(s1));
        check("read_sr2",   32'(sr2), 32'(s2));
        tick();
        // EXEC
        check("exec_write", 32'(write), 32'd0);
        tick();
        // WRITE
        check("wr_write",  32'(write), 32'd1);
        check("wr_done",   32'(done), 32'd1);
        check("wr_dr",     32'(dr), 32'(d));
        check("wr_data",   wrData, exp[31:0]);
        tick();
        ref_regs[d] = exp[31:0];
        ref_z       = (exp[31:0] == 32'h0);
        ref_c       = exp[32];
        check("bank_dr",   bank[d], ref_regs[d]);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
`ifdef REGBANK_SEQ_FLAGS_EN
        check("flag_z", 32'(flag_z), 32'(ref_z));
        check("flag_c", 32'(flag_c), 32'(ref_c));
`endif
    endtask

    initial begin
        int hs0, hs1, hs2, dummy, d0;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_sr1   = 2'd1;
        cmd_sr2   = 2'd2;
        cmd_dr    = 2'd3;
        cmd_imm   = 32'hDEAD_BEEF;

        // Reset held two cycles with a command offered: nothing accepted.
        tick();
        tick();
        check("rst_write",  32'(write), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_ready",  32'(cmd_ready), 32'd0);
        check("rst_wrdata", wrData, 32'h0);
        check("rst_dr",     32'(dr), 32'd0);
        check("rst_sr1",    32'(sr1), 32'd0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy",  32'(busy), 32'd0);

        // LOAD into R2.
        run_cmd(LOAD, 2'd0, 2'd0, 2'd2, 32'h0000_00A5, 1'b0, dummy);
        check("load_r2", bank[2], 32'h0000_00A5);

        // ADD wrap: R0 = FFFF_FFFF, R1 = 2, R3 = R0 + R1 = 1 with carry.
        run_cmd(LOAD, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 1'b0, dummy);
        run_cmd(LOAD, 2'd0, 2'd0, 2'd1, 32'h0000_0002, 1'b0, dummy);
        run_cmd(ADD,  2'd0, 2'd1, 2'd3, 32'h0, 1'b0, dummy);
        check("add_wrap_r3", bank[3], 32'h0000_0001);

        // Reset in the WRITE cycle of MOVE R3 <= R0.
        cmd_op    = MOVE;
        cmd_sr1   = 2'd0;
        cmd_sr2   = 2'd0;
        cmd_dr    = 2'd3;
        cmd_imm   = 32'h0;
        cmd_valid = 1'b1;
        check("mv_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("mv_write_before_rst", 32'(write), 32'd1);
        rst = 1'b1;
        #1;
        check("mv_rst_write", 32'(write), 32'd0);
        check("mv_rst_done",  32'(done), 32'd0);
        d0 = done_cnt;
        tick();
        rst = 1'b0;
        #1;
        ref_z = 1'b0;
        ref_c = 1'b0;
        check("mv_rst_no_done", 32'(done_cnt), 32'(d0));
        check("mv_rst_busy",    32'(busy), 32'd0);
        check("mv_rst_ready",   32'(cmd_ready), 32'd1);
        check("mv_rst_r3",      bank[3], ref_regs[3]);
`ifdef REGBANK_SEQ_FLAGS_EN
        check("mv_rst_flag_z",  32'(flag_z), 32'd0);
        check("mv_rst_flag_c",  32'(flag_c), 32'd0);
`endif

        // SUB with dr aliasing sr1: R1 = 5 - 5 = 0.
        run_cmd(LOAD, 2'd0, 2'd0, 2'd1, 32'd5, 1'b0, dummy);
        run_cmd(LOAD, 2'd0, 2'd0, 2'd2, 32'd5, 1'b0, dummy);
        run_cmd(SUB,  2'd1, 2'd2, 2'd1, 32'h0, 1'b0, dummy);
        check("sub_overlap_r1", bank[1], 32'h0);

        // Back-to-back with cmd_valid held high.
        d0 = done_cnt;
        run_cmd(LOAD, 2'd0, 2'd0, 2'd0, 32'h1234_5678, 1'b1, hs0);
        run_cmd(ADD,  2'd0, 2'd0, 2'd2, 32'h0, 1'b1, hs1);
        run_cmd(SUB,  2'd2, 2'd0, 2'd3, 32'h0, 1'b1, hs2);
        cmd_valid = 1'b0;
        check("b2b_gap01", 32'(hs1 - hs0), 32'd4);
        check("b2b_gap12", 32'(hs2 - hs1), 32'd4);
        check("b2b_dones", 32'(done_cnt - d0), 32'd3);
        check("b2b_r2",    bank[2], 32'h2468_ACF0);
        check("b2b_r3",    bank[3], 32'h1234_5678);

        // Randomized commands against the reference register file.
        for (int n = 0; n < 12; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    (n % 4 == 0) ? 32'h0 : $urandom, 1'b0, dummy);
        end
        for (int r = 0; r < 4; r++) begin
            check($sformatf("final_r%0d", r), bank[r], ref_regs[r]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
